// File: rtl/control_multiciclo.sv
// Multi-cycle main control unit for the MIPS-style core: sequences fetch, decode,
// execute, memory and write-back over one shared ALU and one unified memory port.
module control_multiciclo (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       pc_we,
  output logic       ir_we,
  output logic       reg_we,
  output logic       mem_rd,
  output logic       mem_wr,
  output logic       iord,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [2:0] alu_ctrl,
  output logic [1:0] ext_mode,
  output logic [1:0] pc_src,
  output logic [3:0] state,
  output logic       instr_done,
  output logic       illegal
);

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] F_ADD = 6'h20;
  localparam logic [5:0] F_SUB = 6'h22;
  localparam logic [5:0] F_AND = 6'h24;
  localparam logic [5:0] F_OR  = 6'h25;
  localparam logic [5:0] F_SLT = 6'h2A;

  localparam logic [2:0] ALU_AND  = 3'b000;
  localparam logic [2:0] ALU_OR   = 3'b001;
  localparam logic [2:0] ALU_ADD  = 3'b010;
  localparam logic [2:0] ALU_PASS = 3'b011;
  localparam logic [2:0] ALU_SUB  = 3'b110;
  localparam logic [2:0] ALU_SLT  = 3'b111;

  localparam logic [1:0] EXT_SIGN  = 2'b00;
  localparam logic [1:0] EXT_ZERO  = 2'b01;
  localparam logic [1:0] EXT_UPPER = 2'b10;

  localparam logic [1:0] SRCB_REG    = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

  localparam logic [1:0] PC_ALU    = 2'b00;
  localparam logic [1:0] PC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;

  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_MEM_ADDR  = 4'd2,
    S_MEM_READ  = 4'd3,
    S_MEM_WB    = 4'd4,
    S_MEM_WRITE = 4'd5,
    S_R_EXEC    = 4'd6,
    S_R_WB      = 4'd7,
    S_BRANCH    = 4'd8,
    S_JUMP      = 4'd9,
    S_I_EXEC    = 4'd10,
    S_I_WB      = 4'd11
  } state_t;

  state_t     state_q;
  state_t     state_d;
  logic       funct_ok;
  logic [2:0] r_alu;
  logic       is_mem;
  logic       is_branch;
  logic       is_imm;
  logic       pc_we_c;
  logic       ir_we_c;
  logic       reg_we_c;
  logic       mem_wr_c;
  logic       instr_done_c;
  logic       illegal_c;

  // R-type funct decode; funct_ok also gates entry into R_EXEC
  always_comb begin
    funct_ok = 1'b1;
    r_alu    = ALU_ADD;
    case (funct)
      F_ADD:   r_alu = ALU_ADD;
      F_SUB:   r_alu = ALU_SUB;
      F_AND:   r_alu = ALU_AND;
      F_OR:    r_alu = ALU_OR;
      F_SLT:   r_alu = ALU_SLT;
      default: funct_ok = 1'b0;
    endcase
  end

  assign is_mem    = (opcode == OP_LW) || (opcode == OP_SW);
  assign is_branch = (opcode == OP_BEQ) || (opcode == OP_BNE);
  assign is_imm    = (opcode == OP_ADDI) || (opcode == OP_SLTI) || (opcode == OP_ANDI) ||
                     (opcode == OP_ORI) || (opcode == OP_LUI);

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= S_FETCH;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d      = state_q;
    pc_we_c      = 1'b0;
    ir_we_c      = 1'b0;
    reg_we_c     = 1'b0;
    mem_wr_c     = 1'b0;
    instr_done_c = 1'b0;
    illegal_c    = 1'b0;
    mem_rd       = 1'b0;
    iord         = 1'b0;
    reg_dst      = 1'b0;
    mem_to_reg   = 1'b0;
    alu_src_a    = 1'b0;
    alu_src_b    = SRCB_REG;
    alu_ctrl     = ALU_AND;
    ext_mode     = EXT_SIGN;
    pc_src       = PC_ALU;
    case (state_q)
      S_FETCH: begin
        mem_rd    = 1'b1;
        alu_src_b = SRCB_FOUR;
        alu_ctrl  = ALU_ADD;
        pc_we_c   = mem_ready;
        ir_we_c   = mem_ready;
        if (mem_ready) state_d = S_DECODE;
      end
      // Branch target is precomputed here so BRANCH only needs the compare
      S_DECODE: begin
        alu_src_b = SRCB_IMM_SH;
        alu_ctrl  = ALU_ADD;
        if (is_mem)                                state_d = S_MEM_ADDR;
        else if ((opcode == OP_RTYPE) && funct_ok) state_d = S_R_EXEC;
        else if (is_branch)                        state_d = S_BRANCH;
        else if (opcode == OP_J)                   state_d = S_JUMP;
        else if (is_imm)                           state_d = S_I_EXEC;
        else begin
          state_d   = S_FETCH;
          illegal_c = 1'b1;
        end
      end
      S_MEM_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
        alu_ctrl  = ALU_ADD;
        if (opcode == OP_SW)      state_d = S_MEM_WRITE;
        else if (opcode == OP_LW) state_d = S_MEM_READ;
        else                      state_d = S_FETCH;
      end
      S_MEM_READ: begin
        mem_rd = 1'b1;
        iord   = 1'b1;
        if (mem_ready) state_d = S_MEM_WB;
      end
      S_MEM_WB: begin
        reg_we_c     = 1'b1;
        mem_to_reg   = 1'b1;
        instr_done_c = 1'b1;
        state_d      = S_FETCH;
      end
      S_MEM_WRITE: begin
        mem_wr_c = 1'b1;
        iord     = 1'b1;
        if (mem_ready) begin
          instr_done_c = 1'b1;
          state_d      = S_FETCH;
        end
      end
      S_R_EXEC: begin
        alu_src_a = 1'b1;
        alu_ctrl  = r_alu;
        state_d   = S_R_WB;
      end
      S_R_WB: begin
        reg_we_c     = 1'b1;
        reg_dst      = 1'b1;
        instr_done_c = 1'b1;
        state_d      = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a    = 1'b1;
        alu_ctrl     = ALU_SUB;
        pc_src       = PC_ALUOUT;
        pc_we_c      = ((opcode == OP_BEQ) && zero) || ((opcode == OP_BNE) && !zero);
        instr_done_c = 1'b1;
        state_d      = S_FETCH;
      end
      S_JUMP: begin
        pc_src       = PC_JUMP;
        pc_we_c      = 1'b1;
        instr_done_c = 1'b1;
        state_d      = S_FETCH;
      end
      // Extension mode and ALU op both depend on which immediate form this is
      S_I_EXEC: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
        case (opcode)
          OP_ADDI: begin ext_mode = EXT_SIGN;  alu_ctrl = ALU_ADD;  end
          OP_SLTI: begin ext_mode = EXT_SIGN;  alu_ctrl = ALU_SLT;  end
          OP_ANDI: begin ext_mode = EXT_ZERO;  alu_ctrl = ALU_AND;  end
          OP_ORI:  begin ext_mode = EXT_ZERO;  alu_ctrl = ALU_OR;   end
          OP_LUI:  begin ext_mode = EXT_UPPER; alu_ctrl = ALU_PASS; end
          default: begin ext_mode = EXT_SIGN;  alu_ctrl = ALU_AND;  end
        endcase
        state_d = S_I_WB;
      end
      S_I_WB: begin
        reg_we_c     = 1'b1;
        instr_done_c = 1'b1;
        state_d      = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase
  end

  // Writes and pulses are suppressed during reset so an aborted instruction leaves no trace
  assign pc_we      = rst_n & pc_we_c;
  assign ir_we      = rst_n & ir_we_c;
  assign reg_we     = rst_n & reg_we_c;
  assign mem_wr     = rst_n & mem_wr_c;
  assign instr_done = rst_n & instr_done_c;
  assign illegal    = rst_n & illegal_c;
  assign state      = state_q;

endmodule
